l2_cache_update_arbiter: RTL

Owns the single write port of the L2 cache data memory and schedules it between three sources:
- the L2 pipeline write stage (store/fill updates, cannot be stalled once issued);
- an auxiliary maintenance requester (flush/debug/line-patch engine) using a valid/ready handshake;
- an internal init sequencer that zero-fills every line after reset.

It adds starvation protection for the auxiliary requester by asking upstream issue to pause.

---
 rtl/l2_cache_update_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/l2_cache_update_arbiter.sv
// l2_cache_update_arbiter
// Owns the single write port of the L2 data memory. Three sources share it:
// the init sequencer (zero-fills every line after reset), the pipeline write
// stage (highest priority in RUN, cannot be stalled) and an auxiliary
// maintenance requester on a valid/ready handshake.
//
// Handshake: an aux transfer happens in a cycle where aux_req_valid and
// aux_req_ready are both 1. aux_req_ready is combinational and depends on
// the current pipe_update_enable. The requester must hold valid/index/data
// stable until the transfer. Every issued write shows up on mem_write_* one
// cycle later.
//
// When aux is blocked by the pipeline for STARVE_LIMIT consecutive cycles,
// pipe_stall_req asks upstream to stop issuing. Updates already in flight
// still win. The aux request is granted in the first idle pipeline cycle.
module l2_cache_update_arbiter #(
    parameter int ADDR_WIDTH    = 11,
    parameter int DATA_WIDTH    = 512,
    parameter int INIT_ON_RESET = 1,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_update_enable,
    input  logic [ADDR_WIDTH-1:0] pipe_write_index,
    input  logic [DATA_WIDTH-1:0] pipe_update_data,
    input  logic                  aux_req_valid,
    input  logic [ADDR_WIDTH-1:0] aux_req_index,
    input  logic [DATA_WIDTH-1:0] aux_req_data,
    output logic                  aux_req_ready,
    output logic                  pipe_stall_req,
    output logic                  init_busy,
    output logic                  init_violation,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_index,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  state_dbg
);

    localparam int NUM_LINES = 1 << ADDR_WIDTH;
    localparam int CW        = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH + 1)'(NUM_LINES - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [CW-1:0]     LIMIT       = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0]     STARVE_ONE  = CW'(1);

    state_t                state;
    logic [ADDR_WIDTH:0]   init_cnt;
    logic [CW-1:0]         starve_cnt;
    logic                  aux_fire;

    // The state register is exposed so that checkers can observe the FSM.
    assign state_dbg     = state;

    // Ready only in RUN when the pipeline leaves the port free. Forced low in reset.
    assign aux_req_ready = reset && (state == ST_RUN) && !pipe_update_enable;
    assign aux_fire      = aux_req_valid && aux_req_ready;

    // While reset is held, report the state that will be entered on release.
    assign init_busy     = reset ? (state == ST_INIT) : (INIT_ON_RESET != 0);

    // Single FSM: init sweep, write-port scheduling, starvation tracking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= RESET_STATE;
            init_cnt        <= '0;
            starve_cnt      <= '0;
            pipe_stall_req  <= 1'b0;
            init_violation  <= 1'b0;
            mem_write_en    <= 1'b0;
            mem_write_index <= '0;
            mem_write_data  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    mem_write_en    <= 1'b1;
                    mem_write_index <= init_cnt[ADDR_WIDTH-1:0];
                    mem_write_data  <= '0;
                    init_cnt        <= init_cnt + CNT_ONE;
                    if (init_cnt == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                    // Pipeline updates here are illegal. Drop them and remember it.
                    if (pipe_update_enable) begin
                        init_violation <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pipe_update_enable) begin
                        mem_write_en    <= 1'b1;
                        mem_write_index <= pipe_write_index;
                        mem_write_data  <= pipe_update_data;
                    end else if (aux_req_valid) begin
                        mem_write_en    <= 1'b1;
                        mem_write_index <= aux_req_index;
                        mem_write_data  <= aux_req_data;
                    end else begin
                        mem_write_en    <= 1'b0;
                    end
                    // The counter tracks consecutive blocked aux cycles.
                    // The stall request follows the counter one cycle later.
                    if (aux_fire || !aux_req_valid) begin
                        starve_cnt     <= '0;
                        pipe_stall_req <= 1'b0;
                    end else begin
                        if (pipe_update_enable && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + STARVE_ONE;
                        end
                        if (starve_cnt == LIMIT) begin
                            pipe_stall_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= RESET_STATE;
                end
            endcase
        end
    end

endmodule
